// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_emulator
//  Purpose  : Far end of a 4x3 matrix keypad scanner interface. Watches the
//             scanner's column drive and returns row levels for one emulated
//             key press, including contact bounce, hold time and release gap.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock        in   1   system clock
//    reset        in   1   asynchronous reset, active-high
//    col          in   3   scanner column drive (one-hot, active-high)
//    press_req    in   1   start a press; sampled only when idle
//    press_code   in   4   key to press, 0..11, code = row_idx*3 + col_idx
//    hold_cycles  in   16  stable-closed duration; 0 is treated as 1
//    row          out  4   row return, active-high
//    busy         out  1   press sequence in progress
//    done         out  1   1-cycle pulse at end of sequence
//    err          out  1   1-cycle pulse on a request with code > 11
//    contact      out  1   emulated contact state (1 = closed)
//    press_count  out  8   completed presses, wraps 255 -> 0
//  Configuration
//    KEYPAD_EMU_BOUNCE_EN  defined   : bounce windows around the held phase
//                          undefined : clean contact, IDLE -> HELD -> GAP
// ============================================================================
module keypad_emulator #(
    parameter int BOUNCE_CYCLES = 16,
    parameter int BOUNCE_TOGGLE = 3,
    parameter int GAP_CYCLES    = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  col,
    input  logic        press_req,
    input  logic [3:0]  press_code,
    input  logic [15:0] hold_cycles,
    output logic [3:0]  row,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        contact,
    output logic [7:0]  press_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_BOUNCE_DN = 3'd1,
        S_HELD      = 3'd2,
        S_BOUNCE_UP = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    localparam logic [15:0] c_bounce_last = 16'(BOUNCE_CYCLES - 1);
    localparam logic [15:0] c_toggle_last = 16'(BOUNCE_TOGGLE - 1);
    localparam logic [15:0] c_gap_last    = 16'(GAP_CYCLES - 1);
    localparam logic [3:0]  c_max_code    = 4'd11;

    state_t      state_q,   state_d;
    logic [15:0] cnt_q,     cnt_d;     // cycles elapsed in current state
    logic [15:0] tog_q,     tog_d;     // cycles since last contact inversion
    logic [3:0]  code_q,    code_d;
    logic [15:0] hold_q,    hold_d;    // already clamped to >= 1
    logic        contact_q, contact_d;
    logic        done_q,    done_d;
    logic        err_q,     err_d;
    logic [7:0]  count_q,   count_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tog_q     <= '0;
            code_q    <= '0;
            hold_q    <= 16'd1;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tog_q     <= tog_d;
            code_q    <= code_d;
            hold_q    <= hold_d;
            contact_q <= contact_d;
            done_q    <= done_d;
            err_q     <= err_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tog_d     = tog_q;
        code_d    = code_q;
        hold_d    = hold_q;
        contact_d = contact_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        count_d   = count_q;

        case (state_q)
            S_IDLE: begin
                if (press_req) begin
                    if (press_code <= c_max_code) begin
                        code_d    = press_code;
                        hold_d    = (hold_cycles == 16'd0) ? 16'd1 : hold_cycles;
                        cnt_d     = '0;
                        tog_d     = '0;
                        contact_d = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
                        state_d   = S_BOUNCE_DN;
`else
                        state_d   = S_HELD;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            // Both bounce windows share the toggle scheme; only the starting
            // level (set on entry) and the exit target differ.
            S_BOUNCE_DN, S_BOUNCE_UP: begin
                if (cnt_q == c_bounce_last) begin
                    cnt_d     = '0;
                    tog_d     = '0;
                    contact_d = (state_q == S_BOUNCE_DN);
                    state_d   = (state_q == S_BOUNCE_DN) ? S_HELD : S_GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (tog_q == c_toggle_last) begin
                        tog_d     = '0;
                        contact_d = ~contact_q;
                    end else begin
                        tog_d = tog_q + 16'd1;
                    end
                end
            end

            S_HELD: begin
                if (cnt_q == 16'(hold_q - 16'd1)) begin
                    cnt_d     = '0;
                    tog_d     = '0;
                    contact_d = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
                    state_d   = S_BOUNCE_UP;
`else
                    state_d   = S_GAP;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_GAP: begin
                if (cnt_q == c_gap_last) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    count_d = count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d   = S_IDLE;
                contact_d = 1'b0;
            end
        endcase
    end

    // Row return: the pressed key's row follows its column line whenever the
    // contact is closed. Non-one-hot column drive simply ORs through.
    always_comb begin
        row = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (code_q == 4'(r * 3 + c)) begin
                    row[r] = contact_q & col[c];
                end
            end
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign contact     = contact_q;
    assign press_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_emulator
//  Purpose  : Self-checking bench for keypad_emulator. Randomized and directed
//             key requests; a timing model predicts contact/row/busy per cycle
//             and a scoreboard queue holds the expected done/err events.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_emulator;

    localparam int B   = 16;
    localparam int TOG = 3;
    localparam int G   = 32;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int BW  = B;
`else
    localparam int BW  = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  col = '0;
    logic        press_req = 1'b0;
    logic [3:0]  press_code = '0;
    logic [15:0] hold_cycles = '0;
    logic [3:0]  row;
    logic        busy, done, err, contact;
    logic [7:0]  press_count;

    keypad_emulator #(
        .BOUNCE_CYCLES (B),
        .BOUNCE_TOGGLE (TOG),
        .GAP_CYCLES    (G)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .col         (col),
        .press_req   (press_req),
        .press_code  (press_code),
        .hold_cycles (hold_cycles),
        .row         (row),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .contact     (contact),
        .press_count (press_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit is_err;
        int at_edge;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    // Reference model of the current press, in terms of clock edges.
    bit   m_active = 1'b0;
    int   m_k = 0;        // edge at which the press was accepted
    int   m_code = 0;
    int   m_hl = 1;
    int   m_total = 0;
    int   m_free = 0;     // first edge at which a new request is accepted
    int   m_done_cnt = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
        end
    endtask

    // Expected contact level o cycles after acceptance.
    function automatic bit exp_contact(input int o_in);
        int o = o_in;
        if (BW != 0) begin
            if (o < BW) return ((o / TOG) % 2) == 0;
            o -= BW;
        end
        if (o < m_hl) return 1'b1;
        o -= m_hl;
        if (BW != 0) begin
            if (o < BW) return ((o / TOG) % 2) == 1;
        end
        return 1'b0;
    endfunction

    // Monitor: per-cycle model comparison plus scoreboard for done/err.
    always @(posedge clock) begin
        cyc = cyc + 1;
        #1;
        if (mon_en) begin
            bit       eb, ec;
            logic [3:0] er;
            int       o;
            o  = cyc - m_k;
            eb = m_active && (cyc >= m_k) && (o < m_total);
            ec = eb ? exp_contact(o) : 1'b0;
            er = '0;
            if (ec) er[m_code / 3] = col[m_code % 3];
            chk("busy", int'(busy), int'(eb));
            chk("contact", int'(contact), int'(ec));
            chk("row", int'(row), int'(er));

            while (sb.size() > 0 && sb[0].at_edge < cyc) begin
                exp_t m;
                m = sb.pop_front();
                chk(m.is_err ? "missing_err" : "missing_done", 0, 1);
            end
            if (done || err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {done, err}, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("event_kind", {done, err}, e.is_err ? 1 : 2);
                    chk("event_cycle", cyc, e.at_edge);
                    if (!e.is_err) chk("press_count", int'(press_count), e.cnt);
                end
            end
        end
    end

    // Drive one cycle of inputs and update the model for the coming edge.
    task automatic step(input bit req, input int code, input int hold, input logic [2:0] c);
        int k;
        @(negedge clock);
        press_req   = req;
        press_code  = 4'(code);
        hold_cycles = 16'(hold);
        col         = c;
        k = cyc + 1;
        if (req && k >= m_free) begin
            if (code <= 11) begin
                m_active = 1'b1;
                m_k      = k;
                m_code   = code;
                m_hl     = (hold == 0) ? 1 : hold;
                m_total  = 2 * BW + m_hl + G;
                m_free   = k + m_total + 1;
                m_done_cnt++;
                sb.push_back('{1'b0, k + m_total, m_done_cnt % 256});
            end else begin
                sb.push_back('{1'b1, k, 0});
            end
        end
    endtask

    task automatic rnd_col_steps(input int n, input logic [2:0] c);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, c);
    endtask

    initial begin
        int guard;

        // Reset values
        @(negedge clock);
        @(negedge clock);
        col = 3'b111;
        #1;
        chk("rst_row", int'(row), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_contact", int'(contact), 0);
        chk("rst_press_count", int'(press_count), 0);
        @(negedge clock);
        reset  = 1'b0;
        m_free = cyc + 1;
        mon_en = 1'b1;

        // Asynchronous reset in the middle of HELD aborts with no done
        step(1'b1, 4, 20, 3'b111);
        rnd_col_steps(BW + 8, 3'b111);
        reset      = 1'b1;
        m_active   = 1'b0;
        m_free     = 32'h7fff_ffff;
        m_done_cnt = 0;
        sb.delete();
        #1;
        chk("abort_row", int'(row), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_contact", int'(contact), 0);
        chk("abort_press_count", int'(press_count), 0);
        @(negedge clock);
        @(negedge clock);
        reset  = 1'b0;
        m_free = cyc + 1;
        rnd_col_steps(60, 3'b111);

        // Directed presses: code 5 on col 100, code 0 on col 001
        step(1'b1, 5, 10, 3'b100);
        rnd_col_steps(2 * BW + 50, 3'b100);
        step(1'b1, 0, 5, 3'b001);
        rnd_col_steps(2 * BW + 45, 3'b001);

        // Invalid code, then requests while busy are ignored
        step(1'b1, 13, 3, 3'b111);
        rnd_col_steps(2, 3'b111);
        step(1'b1, 3, 4, 3'b010);
        for (int i = 0; i < 6; i++) step(1'b1, 9, 2, 3'b010);
        rnd_col_steps(2 * BW + 45, 3'b010);

        // Code 7 with the scanner rotating the column drive
        step(1'b1, 7, 12, 3'b001);
        for (int i = 0; i < 2 * BW + 50; i++) begin
            logic [2:0] rc;
            rc = 3'b001 << (i % 3);
            step(1'b0, 0, 0, rc);
        end

        // Random traffic, including non-one-hot column drive
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 6)), 3'($urandom_range(0, 7)));
        end

        // Back-to-back presses with zero hold until the counter wraps
        guard = 0;
        while (m_done_cnt < 300 && guard < 40000) begin
            step(1'b1, int'($urandom_range(0, 11)), 0, 3'($urandom_range(0, 7)));
            guard++;
        end
        chk("wrap_reached", int'(m_done_cnt >= 300), 1);

        // Drain outstanding events
        guard = 0;
        while (cyc <= m_free + 2 && guard < 500) begin
            step(1'b0, 0, 0, 3'($urandom_range(0, 7)));
            guard++;
        end
        @(negedge clock);
        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
